spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arb_pkg.sv | 19 +
 rtl/spi_rr_pick.sv | 28 ++
 rtl/spi_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_arb_pkg
// Description : Shared constants and state encodings for the SPI arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

    localparam int NCH        = 4;
    localparam int FRAME_BITS = 16;
    localparam int READ_BITS  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/spi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : spi_rr_pick
// Description : Combinational round-robin picker, searching from last+1.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_pick
    import spi_arb_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [1:0]     last,
    output logic           valid,
    output logic [1:0]     grant
);

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid = |req;
        grant = last;
        for (int k = NCH; k >= 1; k--) begin
            if (req[last + 2'(k)]) begin
                grant = last + 2'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_arbiter
// Description : Four-channel round-robin SPI master with 16-bit R/W frames.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CLKDIV = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       req,
    input  logic [NCH-1:0]       rw,
    input  logic [7*NCH-1:0]     addr,
    input  logic [8*NCH-1:0]     wdata,
    output logic [NCH-1:0]       ack,
    output logic [READ_BITS-1:0] rdata,
    output logic                 busy,
    output logic [NCH-1:0]       spi_cs,
    output logic [NCH-1:0]       spi_sclk,
    output logic [NCH-1:0]       spi_sdin_o,
    output logic [NCH-1:0]       spi_sdin_t,
    input  logic [NCH-1:0]       spi_sdin_i
);

    localparam logic [7:0] c_div_last = 8'(CLKDIV - 1);
    localparam logic [3:0] c_last_bit = 4'(FRAME_BITS - 1);
    localparam logic [3:0] c_turn_bit = 4'(FRAME_BITS - READ_BITS - 1);

    logic [1:0]            r_state;
    logic [1:0]            r_last;
    logic [1:0]            r_gnt;
    logic [7:0]            r_cnt;
    logic                  r_hi;
    logic [3:0]            r_bit;
    logic                  r_rd;
    logic [FRAME_BITS-2:0] r_frame;
    logic [READ_BITS-1:0]  r_rx;

    logic                  w_valid;
    logic [1:0]            w_grant;
    logic [FRAME_BITS-1:0] w_frame;

    spi_rr_pick u_pick (
        .req   (req),
        .last  (r_last),
        .valid (w_valid),
        .grant (w_grant)
    );

    always_comb begin
        w_frame = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_grant == 2'(k)) begin
                w_frame = {rw[k], addr[7*k +: 7], wdata[8*k +: 8]};
            end
        end
    end

    // Frame bit 15 leaves at grant, so r_frame only keeps the remaining bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last     <= 2'd3;
            r_gnt      <= 2'd0;
            r_cnt      <= '0;
            r_hi       <= 1'b0;
            r_bit      <= '0;
            r_rd       <= 1'b0;
            r_frame    <= '0;
            r_rx       <= '0;
            ack        <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
            spi_cs     <= '1;
            spi_sclk   <= '0;
            spi_sdin_o <= '0;
            spi_sdin_t <= '0;
        end else begin
            ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_valid) begin
                        r_gnt               <= w_grant;
                        r_last              <= w_grant;
                        r_rd                <= w_frame[FRAME_BITS-1];
                        r_frame             <= w_frame[FRAME_BITS-2:0];
                        r_bit               <= '0;
                        r_hi                <= 1'b0;
                        busy                <= 1'b1;
                        spi_cs              <= ~(4'b0001 << w_grant);
                        spi_sdin_o[w_grant] <= w_frame[FRAME_BITS-1];
                        spi_sdin_t[w_grant] <= 1'b1;
                        r_state             <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt           <= '0;
                        r_hi            <= 1'b1;
                        spi_sclk[r_gnt] <= 1'b1;
                        r_state         <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != c_div_last) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else begin
                        r_cnt <= '0;
                        if (r_hi) begin
                            r_rx            <= {r_rx[READ_BITS-2:0], spi_sdin_i[r_gnt]};
                            r_hi            <= 1'b0;
                            spi_sclk[r_gnt] <= 1'b0;
                            if (r_bit != c_last_bit) begin
                                spi_sdin_o[r_gnt] <= r_frame[FRAME_BITS-2];
                                r_frame           <= {r_frame[FRAME_BITS-3:0], 1'b0};
                            end
                            // Hand the line to the slave before the data byte of a read.
                            if (r_rd && r_bit == c_turn_bit) begin
                                spi_sdin_t[r_gnt] <= 1'b0;
                            end
                        end else if (r_bit == c_last_bit) begin
                            spi_cs     <= '1;
                            spi_sclk   <= '0;
                            spi_sdin_o <= '0;
                            spi_sdin_t <= '0;
                            ack[r_gnt] <= 1'b1;
                            rdata      <= r_rx;
                            r_state    <= ST_GAP;
                        end else begin
                            r_bit           <= r_bit + 4'd1;
                            r_hi            <= 1'b1;
                            spi_sclk[r_gnt] <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_div_last) begin
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
